// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and a
// constant helper that sizes the bit counter.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Number of bits needed to hold the values 0 .. value-1 (at least 1).
   function automatic int clog2(input int value);
      int bits;
      bits = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) bits = i + 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/addsub.sv
// Existing adder/subtractor of the arithmetic unit: s = a + b (as=0) or
// s = a - b (as=1), two's complement, carry out dropped.
module addsub #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         as,
   output logic [W-1:0] s
);

   // Subtract by adding the one's complement of b plus a carry-in of one.
   assign s = a + (b ^ {W{as}}) + {{(W-1){1'b0}}, as};

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, with a
// start/busy/done handshake. The trial subtraction runs on an addsub in
// subtract mode.
// Build option: define DIV_SIGNED_EN for two's-complement operands (adds a
// FIX state that applies result signs; one extra cycle of latency).
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = clog2(WIDTH);

   state_t           state;
   logic [WIDTH:0]   r;          // partial remainder, one guard bit
   logic [WIDTH-1:0] q;          // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] d;          // divisor (magnitude in the signed build)
   logic [CW-1:0]    cnt;        // remaining quotient bits minus one
   logic             dz;         // current operation is a divide by zero

   logic [WIDTH:0]   shifted;    // remainder with next dividend bit appended
   logic [WIDTH:0]   trial_a;
   logic [WIDTH:0]   trial_b;
   logic [WIDTH:0]   trial_s;
   logic [WIDTH-1:0] dvd_mag;    // dividend as loaded into q
   logic [WIDTH-1:0] dvs_mag;    // divisor as loaded into d

   assign shifted = {r[WIDTH-1:0], q[WIDTH-1]};

`ifdef DIV_SIGNED_EN
   logic             neg_q;      // operand signs differ: quotient is negative
   logic             neg_r;      // dividend negative: remainder is negative
   logic [WIDTH-1:0] neg_in;
   logic [WIDTH-1:0] neg_s;

   // Operand routing: while idle the trial subtractor negates the divisor;
   // otherwise it performs the restoring trial subtraction.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      trial_a = shifted;
      trial_b = {1'b0, d};
      if (state == IDLE) begin
         trial_a = '0;
         trial_b = {divisor[WIDTH-1], divisor};
      end
   end

   // Negator input: dividend while idle, quotient in FIX, remainder in DONE.
   always_comb begin
      neg_in = dividend;
      if (state == FIX)       neg_in = q;
      else if (state == DONE) neg_in = r[WIDTH-1:0];
   end

   addsub #(.W(WIDTH)) u_negate (
      .a  ('0),
      .b  (neg_in),
      .as (1'b1),
      .s  (neg_s)
   );

   assign dvd_mag = dividend[WIDTH-1] ? neg_s : dividend;
   assign dvs_mag = divisor[WIDTH-1] ? trial_s[WIDTH-1:0] : divisor;
`else
   assign trial_a = shifted;
   assign trial_b = {1'b0, d};
   assign dvd_mag = dividend;
   assign dvs_mag = divisor;
`endif

   addsub #(.W(WIDTH + 1)) u_trial (
      .a  (trial_a),
      .b  (trial_b),
      .as (1'b1),
      .s  (trial_s)
   );

   // Control FSM with datapath registers and registered handshake/results.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state       <= IDLE;
         r           <= '0;
         q           <= '0;
         d           <= '0;
         cnt         <= '0;
         dz          <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !busy) begin
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
                  cnt         <= CW'(WIDTH - 1);
                  if (divisor == '0) begin
                     // Result is known immediately: all-ones quotient and
                     // the untouched dividend as remainder.
                     q     <= '1;
                     r     <= {1'b0, dividend};
                     d     <= '0;
                     dz    <= 1'b1;
                     state <= DONE;
`ifdef DIV_SIGNED_EN
                     neg_q <= 1'b0;
                     neg_r <= 1'b0;
`endif
                  end else begin
                     q     <= dvd_mag;
                     r     <= '0;
                     d     <= dvs_mag;
                     dz    <= 1'b0;
                     state <= RUN;
`ifdef DIV_SIGNED_EN
                     neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                     neg_r <= dividend[WIDTH-1];
`endif
                  end
               end
            end

            RUN: begin
               if (!trial_s[WIDTH]) begin
                  r <= trial_s;
                  q <= {q[WIDTH-2:0], 1'b1};
               end else begin
                  r <= shifted;
                  q <= {q[WIDTH-2:0], 1'b0};
               end
               if (cnt == '0) begin
`ifdef DIV_SIGNED_EN
                  state <= FIX;
`else
                  state <= DONE;
`endif
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            FIX: begin
`ifdef DIV_SIGNED_EN
               if (neg_q) q <= neg_s;
               state <= DONE;
`else
               state <= IDLE;
`endif
            end

            DONE: begin
               done        <= 1'b1;
               busy        <= 1'b0;
               quotient    <= q;
               div_by_zero <= dz;
`ifdef DIV_SIGNED_EN
               remainder   <= neg_r ? neg_s : r[WIDTH-1:0];
`else
               remainder   <= r[WIDTH-1:0];
`endif
               state       <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8). Stimulus pushes expected
// results into a scoreboard queue; a monitor pops and compares on done.
// Honours DIV_SIGNED_EN to select signed expectations and latency.
module tb_seq_divider;

   localparam int WIDTH = 8;
`ifdef DIV_SIGNED_EN
   localparam int LAT = WIDTH + 2;
`else
   localparam int LAT = WIDTH + 1;
`endif

   typedef struct {
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      logic             dz;
      string            name;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   seq_divider #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            check("done_expected", 32'(sb.size() != 0), 32'd1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_quotient"},  32'(quotient),    32'(e.q));
            check({e.name, "_remainder"}, 32'(remainder),   32'(e.r));
            check({e.name, "_dbz"},       32'(div_by_zero), 32'(e.dz));
         end
      end
   end

   // Called just after a negedge: present operands, let edge 0 accept them,
   // release start at the following negedge.
   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                           input logic ez, input bit push, input string name);
      exp_t e;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      if (push) begin
         e.q = eq; e.r = er; e.dz = ez; e.name = name;
         sb.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check({name, "_dbz_cleared"}, 32'(div_by_zero), 32'd0);
   endtask

   // Counts edges after acceptance until done; checks latency and busy.
   // inject_k>0 pulses start with 9/3 so that edge inject_k+1 samples it.
   task automatic wait_done(input int exp_lat, input int inject_k, input string name);
      int k;
      int busy_bad;
      k = 0;
      busy_bad = 0;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
         if (!done && !busy) busy_bad++;
         if (inject_k > 0 && k == inject_k) begin
            dividend = 8'd9;
            divisor  = 8'd3;
            start    = 1'b1;
         end else if (inject_k > 0 && k == inject_k + 1) begin
            start = 1'b0;
         end
      end
      check({name, "_latency"},     32'(k),        32'(exp_lat));
      check({name, "_busy_window"}, 32'(busy_bad), 32'd0);
      check({name, "_busy_at_done"}, 32'(busy),    32'd0);
   endtask

   initial begin
      int seen;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      check("reset_busy",      32'(busy),        32'd0);
      check("reset_done",      32'(done),        32'd0);
      check("reset_quotient",  32'(quotient),    32'd0);
      check("reset_remainder", 32'(remainder),   32'd0);
      check("reset_dbz",       32'(div_by_zero), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 100 / 7 = 14 r 2 (same in both builds)
      start_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1, "div_100_7");
      wait_done(LAT, 0, "div_100_7");
      @(negedge clk);

      // Divide by zero, then check the flag and results are held
      start_op(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1'b1, "div_5_0");
      wait_done(1, 0, "div_5_0");
      repeat (3) @(negedge clk);
      check("dbz_hold_flag",     32'(div_by_zero), 32'd1);
      check("dbz_hold_quotient", 32'(quotient),    32'hFF);

      // 255 / 1 (signed build: -1 / 1 = -1 r 0, same bit pattern)
      start_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b1, "div_255_1");
      wait_done(LAT, 0, "div_255_1");
      @(negedge clk);

      // 3 / 200 with a start pulse while busy (ignored), then a start held
      // in the done cycle for 9 / 3
`ifdef DIV_SIGNED_EN
      start_op(8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 1'b1, "div_3_m56");
`else
      start_op(8'd3, 8'd200, 8'd0, 8'd3, 1'b0, 1'b1, "div_3_200");
`endif
      wait_done(LAT, 3, "div_3_200");
      start_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b1, "div_9_3_b2b");
      wait_done(LAT, 0, "div_9_3_b2b");
      @(negedge clk);

      // Reset in the middle of 200 / 9 aborts it without a done pulse
      start_op(8'd200, 8'd9, 8'd0, 8'd0, 1'b0, 1'b0, "abort");
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_busy",      32'(busy),        32'd0);
      check("abort_done",      32'(done),        32'd0);
      check("abort_quotient",  32'(quotient),    32'd0);
      check("abort_remainder", 32'(remainder),   32'd0);
      check("abort_dbz",       32'(div_by_zero), 32'd0);
      rst_n = 1'b1;
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("abort_no_done", 32'(seen), 32'd0);

`ifdef DIV_SIGNED_EN
      // -56 / 9 = -6 r -2
      start_op(8'd200, 8'd9, 8'hFA, 8'hFE, 1'b0, 1'b1, "div_m56_9");
      wait_done(LAT, 0, "div_m56_9");
      @(negedge clk);
      start_op(8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b1, "div_m100_7");
      wait_done(LAT, 0, "div_m100_7");
      @(negedge clk);
      start_op(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, "div_min_m1");
      wait_done(LAT, 0, "div_min_m1");
      @(negedge clk);
      start_op(8'd7, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b1, "div_7_m2");
      wait_done(LAT, 0, "div_7_m2");
      @(negedge clk);
`else
      start_op(8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 1'b1, "div_200_9");
      wait_done(LAT, 0, "div_200_9");
      @(negedge clk);
      start_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b1, "div_255_255");
      wait_done(LAT, 0, "div_255_255");
      @(negedge clk);
      start_op(8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 1'b1, "div_254_255");
      wait_done(LAT, 0, "div_254_255");
      @(negedge clk);
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
